// File: rtl/aha_clock_gate_ctrl.sv
// -----------------------------------------------------------------------------
// aha_clock_gate_ctrl
//
// Purpose:
//   Auto-gating controller for the functional enable (E) of a single AhaClockGate
//   ICG cell. It runs on the free-running source clock that also feeds the ICG
//   CP pin. When the downstream domain has been idle for a programmable
//   hysteresis, the controller gates the clock. It re-enables the clock on
//   activity, force-on or a wake request, and it reports readiness through a
//   4-phase req/ack handshake once a fixed settle time has passed. It also
//   keeps a saturating count of gating events.
//
// Ports:
//   CLK          in   free-running source clock (same net as ICG CP)
//   RESETn       in   asynchronous active-low reset
//   AUTO_EN      in   enables automatic gating
//   IDLE         in   domain idle, synchronous to CLK
//   IDLE_THRESH  in   idle cycles required before gating (quasi-static)
//   FORCE_ON     in   keeps or returns the clock on
//   WAKE_REQ     in   4-phase wake request
//   CNT_CLR      in   synchronous clear of GATE_CNT
//   CLK_EN       out  drives ICG E; low only while gated
//   WAKE_ACK     out  high when the clock is running and settled
//   GATED        out  high while the clock is gated
//   GATE_CNT     out  saturating count of entries into the gated state
//
// Handshake (WAKE_REQ / WAKE_ACK, 4-phase):
//   A requester raises WAKE_REQ and holds it until it sees WAKE_ACK=1. It may
//   drop WAKE_REQ after that. While WAKE_REQ is high, gating cannot start, so
//   WAKE_ACK stays high for the whole REQ-high phase once it has risen. The
//   ICG TE pin is driven outside this block by DFT scan-enable.
// -----------------------------------------------------------------------------
module aha_clock_gate_ctrl #(
  parameter int THRESH_W      = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int GCNT_W        = 16
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                AUTO_EN,
  input  logic                IDLE,
  input  logic [THRESH_W-1:0] IDLE_THRESH,
  input  logic                FORCE_ON,
  input  logic                WAKE_REQ,
  input  logic                CNT_CLR,
  output logic                CLK_EN,
  output logic                WAKE_ACK,
  output logic                GATED,
  output logic [GCNT_W-1:0]   GATE_CNT
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_COUNT = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [THRESH_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]          settle_cnt_q, settle_cnt_d;
  logic [GCNT_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic                hold;
  logic                gate_entry;

  // Conditions that allow the clock to be, or to stay, gated.
  assign hold = AUTO_EN & IDLE & ~FORCE_ON & ~WAKE_REQ;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= ST_RUN;
      idle_cnt_q   <= '0;
      settle_cnt_q <= '0;
      gate_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      gate_cnt_q   <= gate_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    settle_cnt_d = settle_cnt_q;
    gate_entry   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hold) begin
          state_d    = ST_COUNT;
          idle_cnt_d = IDLE_THRESH;
        end
      end
      ST_COUNT: begin
        // An abort has priority over gating in the same cycle.
        if (!hold) begin
          state_d = ST_RUN;
        end else if (idle_cnt_q == '0) begin
          state_d    = ST_GATED;
          gate_entry = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q - 1'b1;
        end
      end
      ST_GATED: begin
        if (!hold) begin
          state_d      = ST_WAKE;
          settle_cnt_d = SETTLE_LOAD;
        end
      end
      ST_WAKE: begin
        // Settling cannot be aborted: the clock is already running again.
        if (settle_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // A clear wins over an increment that happens in the same cycle.
  always_comb begin
    gate_cnt_d = gate_cnt_q;
    if (CNT_CLR) begin
      gate_cnt_d = '0;
    end else if (gate_entry && !(&gate_cnt_q)) begin
      gate_cnt_d = gate_cnt_q + GCNT_W'(1);
    end
  end

  // The outputs are decoded only from flops, so no input reaches them combinationally.
  assign CLK_EN   = (state_q != ST_GATED);
  assign GATED    = (state_q == ST_GATED);
  assign WAKE_ACK = (state_q == ST_RUN) || (state_q == ST_COUNT);
  assign GATE_CNT = gate_cnt_q;

endmodule

// File: tb/tb_aha_clock_gate_ctrl.sv
module tb_aha_clock_gate_ctrl;

  localparam int TW = 8;
  localparam int SC = 4;
  localparam int GW = 6;             // narrow counter so saturation is reachable
  localparam int W  = 3 + GW;
  localparam int CNT_MAX = (1 << GW) - 1;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          AUTO_EN = 1'b0;
  logic          IDLE = 1'b0;
  logic [TW-1:0] IDLE_THRESH = '0;
  logic          FORCE_ON = 1'b0;
  logic          WAKE_REQ = 1'b0;
  logic          CNT_CLR = 1'b0;
  logic          CLK_EN;
  logic          WAKE_ACK;
  logic          GATED;
  logic [GW-1:0] GATE_CNT;

  aha_clock_gate_ctrl #(
    .THRESH_W(TW), .SETTLE_CYCLES(SC), .GCNT_W(GW)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .AUTO_EN(AUTO_EN), .IDLE(IDLE),
    .IDLE_THRESH(IDLE_THRESH), .FORCE_ON(FORCE_ON), .WAKE_REQ(WAKE_REQ),
    .CNT_CLR(CNT_CLR), .CLK_EN(CLK_EN), .WAKE_ACK(WAKE_ACK), .GATED(GATED),
    .GATE_CNT(GATE_CNT)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got clk_en/ack/gated/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d at %0t",
               name, act[W-1], act[W-2], act[W-3], act[GW-1:0],
               exp[W-1], exp[W-2], exp[W-3], exp[GW-1:0], $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare away from the active edge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("scoreboard", {CLK_EN, WAKE_ACK, GATED, GATE_CNT}, e);
    end
  end

  // ---------------- reference model ----------------
  // The model tracks the length of the current idle run, the remaining settle
  // time and a gated flag. It does not use an explicit state machine.
  bit m_gated;
  int m_rem;     // settle cycles still to go before the clock counts as ready
  int m_run;     // consecutive sampled hold cycles while the clock is ready
  int m_cnt;

  task automatic model_reset();
    m_gated = 0; m_rem = 0; m_run = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit a, input bit i, input bit f, input bit w, input bit c);
    bit hold;
    hold = a && i && !f && !w;
    if (m_gated) begin
      if (!hold) begin
        m_gated = 0;
        m_rem   = SC;
      end
    end else if (m_rem > 0) begin
      m_rem--;
    end else if (hold) begin
      m_run++;
      // First hold edge plus IDLE_THRESH further edges, then gate on the next one.
      if (m_run > int'(IDLE_THRESH) + 1) begin
        m_gated = 1;
        m_run   = 0;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end else begin
      m_run = 0;
    end
    if (c) m_cnt = 0;
  endtask

  function automatic logic [W-1:0] model_out();
    logic [W-1:0] o;
    o = {!m_gated, (!m_gated && m_rem == 0), m_gated, GW'(m_cnt)};
    return o;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit a, input bit i, input bit f, input bit w, input bit c);
    AUTO_EN = a; IDLE = i; FORCE_ON = f; WAKE_REQ = w; CNT_CLR = c;
    @(posedge CLK);
    model_edge(a, i, f, w, c);
    exp_q.push_back(model_out());
    #2;
  endtask

  task automatic hold_n(input int n);
    for (int k = 0; k < n; k++) step(1, 1, 0, 0, 0);
  endtask

  task automatic wake_n(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    #1;
    check("reset_init", {CLK_EN, WAKE_ACK, GATED, GATE_CNT}, {1'b1, 1'b1, 1'b0, GW'(0)});
    #3 RESETn = 1'b1;

    // Basic gating: threshold 3, gated four edges after the first hold edge.
    IDLE_THRESH = 8'd3;
    hold_n(6);
    // Wake through the request handshake, then drop the request and re-gate.
    for (int k = 0; k < SC + 2; k++) step(1, 1, 0, 1, 0);
    hold_n(6);
    wake_n(SC + 1);

    // Zero threshold.
    IDLE_THRESH = 8'd0;
    hold_n(3);
    wake_n(SC + 1);

    // Abort one edge before gating, then a same-cycle FORCE_ON abort.
    IDLE_THRESH = 8'd3;
    hold_n(3);
    wake_n(1);
    hold_n(4);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    wake_n(2);

    // CNT_CLR on the same edge as a gating entry.
    IDLE_THRESH = 8'd0;
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    hold_n(2);
    wake_n(SC + 1);

    // Saturation: more gate/wake rounds than the counter can hold.
    for (int r = 0; r < CNT_MAX + 6; r++) begin
      hold_n(2);
      wake_n(SC + 1);
    end

    // Asynchronous reset while in the counting phase with a saturated counter.
    IDLE_THRESH = 8'd10;
    hold_n(4);
    @(negedge CLK);
    #1 RESETn = 1'b0;
    #1;
    check("async_reset", {CLK_EN, WAKE_ACK, GATED, GATE_CNT}, {1'b1, 1'b1, 1'b0, GW'(0)});
    model_reset();
    #1 RESETn = 1'b1;

    // AUTO_EN low: the clock must stay enabled regardless of IDLE.
    for (int k = 0; k < 20; k++) step(0, 1, 0, 0, 0);

    // Randomized traffic, biased towards long idle runs.
    IDLE_THRESH = 8'd2;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        step(1, 0, 0, 0, 0);
        IDLE_THRESH = TW'($urandom_range(0, 6));
      end else begin
        step($urandom_range(0, 99) < 95, $urandom_range(0, 99) < 85,
             $urandom_range(0, 99) < 3,  $urandom_range(0, 99) < 5,
             $urandom_range(0, 99) < 2);
      end
    end

    wake_n(SC + 2);
    @(negedge CLK);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending entries want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
